ram_param: RTL

- Parametrised single-port synchronous RAM for the mini-CPU data/instruction store; successor to the fixed 16x8 RAM.
- Adds generic width/depth, selectable read latency (1 or 2 cycles) and a read-valid strobe.
- Adds a post-reset clear sequencer that zeroes every word and reports busy while doing so.
- Sits between the CPU load/store unit and the memory array.

---
 rtl/ram_param_if.sv | 29 ++
 rtl/ram_param.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ram_param_if.sv
// Request/response bundle between the load/store unit and ram_param.
// Latency: none, wiring only.
// Backpressure: none; busy tells the requester that requests are being ignored.
interface ram_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              pinj;
    logic [DATA_W-1:0] dout;
    logic              rvalid;
    logic              busy;
    logic              perr;

    // Requester side: drives the access, observes the read response.
    modport master (
        output en, we, addr, din, pinj,
        input  dout, rvalid, busy, perr
    );

    // Memory side: consumes the access, returns the read response.
    modport slave (
        input  en, we, addr, din, pinj,
        output dout, rvalid, busy, perr
    );
endinterface

// File: rtl/ram_param.sv
// Parametrised single-port RAM with post-reset clear sequencer; optional parity via RAM_PARITY_EN.
// Latency: reads return RD_LAT (1 or 2) edges after the request edge; writes take effect on the request edge.
// Backpressure: none; requests seen while busy (clearing) are silently dropped.
module ram_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           areset,
    ram_param_if.slave     bus
);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              busy_q;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              in_range;
    logic              clr_wr;
    logic              wr_req;
    logic              rd_req;
    logic [DATA_W-1:0] rd_dat;
    logic              rd_perr;

    // Read response pipeline; the last stage drives the outputs.
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] perr_q;
    logic [DATA_W-1:0] dat_q [RD_LAT];

    // Out-of-range addresses are only possible when DEPTH < 2**ADDR_W.
    assign in_range = {1'b0, bus.addr} < DEPTH_EXT;

    // Reset wins over everything, so a request on the reset edge is lost.
    assign clr_wr = !areset && (state == CLEAR);
    assign wr_req = !areset && (state == READY) && bus.en && bus.we && in_range;
    assign rd_req = !areset && (state == READY) && bus.en && !bus.we;

    // Out-of-range reads still respond, with zero data and no parity error.
    assign rd_dat = in_range ? mem[bus.addr] : '0;

`ifdef RAM_PARITY_EN
    logic par_mem [0:DEPTH-1];

    // Parity array shadows the data array; pinj flips the stored bit for fault injection.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            par_mem[ptr] <= 1'b0;
        end else if (wr_req) begin
            par_mem[bus.addr] <= (^bus.din) ^ bus.pinj;
        end
    end

    assign rd_perr = in_range && (par_mem[bus.addr] != (^mem[bus.addr]));
`else
    logic unused_pinj;

    assign unused_pinj = bus.pinj;
    assign rd_perr     = 1'b0;
`endif

    // Clear sequencer: sweep every word once after reset, then serve requests.
    always_ff @(posedge clk) begin
        if (areset) begin
            state  <= CLEAR;
            ptr    <= '0;
            busy_q <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (ptr == LAST_PTR) begin
                        state  <= READY;
                        ptr    <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                READY: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= CLEAR;
                    ptr    <= '0;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    // Data array write port, shared between the clear sweep and CPU stores.
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[ptr] <= '0;
        end else if (wr_req) begin
            mem[bus.addr] <= bus.din;
        end
    end

    // Read pipeline: data stages only load on a valid read so dout holds between reads.
    always_ff @(posedge clk) begin
        if (areset) begin
            vld_q  <= '0;
            perr_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= rd_req;
            perr_q[0] <= rd_req && rd_perr;
            if (rd_req) begin
                dat_q[0] <= rd_dat;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                perr_q[i] <= perr_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign bus.dout   = dat_q[RD_LAT-1];
    assign bus.rvalid = vld_q[RD_LAT-1];
    assign bus.perr   = perr_q[RD_LAT-1];
    assign bus.busy   = busy_q;

endmodule
